// File: rtl/find_string_pkg.sv
`default_nettype none
// ============================================================================
// Module   : find_string_pkg
// Brief    : Constants and state type shared between the nhap_state
//            entry front end and the scan/output stage of the string finder.
// Revision : 1.0 - initial release
// ============================================================================
package find_string_pkg;

  // Maximum string length in bits (width of stringo)
  localparam int MAX_LEN = 40;
  // Pattern length in bits (width of in_comp)
  localparam int PAT_LEN = 4;
  // Width of the string bit counter
  localparam int CNT_W   = 8;

  // Entry front-end states: string entry, pattern entry, data ready
  typedef enum logic [1:0] {
    S_STR = 2'd0,
    S_PAT = 2'd1,
    S_RDY = 2'd2
  } state_t;

endpackage : find_string_pkg
`default_nettype wire

// File: rtl/nhap_state.sv
`default_nettype none
// ============================================================================
// Module   : nhap_state
// Brief    : Input-side front end of the string finder. Collects a serial
//            bit string (first bit into stringo[0]) and then a pattern word
//            (first bit ends up as MSB of in_comp) from one-cycle strobes,
//            then raises ready and holds every output frozen until the
//            scanner asserts roll_back.
//            Optional feature macro: NHAP_BACKSPACE_EN (del removes the last
//            entered string bit while in string entry).
// Revision : 1.0 - initial release
// ============================================================================
module nhap_state #(
  parameter int MAX_LEN = find_string_pkg::MAX_LEN,
  parameter int PAT_LEN = find_string_pkg::PAT_LEN,
  parameter int CNT_W   = find_string_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               enter,
  input  logic               del,
  input  logic               roll_back,
  output logic [0:MAX_LEN-1] stringo,
  output logic [CNT_W-1:0]   counter,
  output logic [PAT_LEN-1:0] in_comp,
  output logic               ready,
  output logic               err
);

  import find_string_pkg::state_t;
  import find_string_pkg::S_STR;
  import find_string_pkg::S_PAT;
  import find_string_pkg::S_RDY;

  // Pattern counter must be able to hold the value PAT_LEN itself
  localparam int                 PC_W      = $clog2(PAT_LEN + 1);
  localparam logic [CNT_W-1:0]   C_MAX_CNT = CNT_W'(MAX_LEN);
  localparam logic [CNT_W-1:0]   C_PAT_MIN = CNT_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   C_ONE     = CNT_W'(1);
  localparam logic [PC_W-1:0]    C_PAT_FUL = PC_W'(PAT_LEN);
  localparam logic [PC_W-1:0]    C_PC_ONE  = PC_W'(1);

  state_t               state_q;
  logic [0:MAX_LEN-1]   stringo_q;
  logic [CNT_W-1:0]     counter_q;
  logic [PAT_LEN-1:0]   in_comp_q;
  logic [PC_W-1:0]      pat_cnt_q;
  logic                 ready_q;
  logic                 err_q;

  // del only has an effect when backspace support is compiled in
  logic                 w_unused_del;
  assign w_unused_del = del;

  assign stringo = stringo_q;
  assign counter = counter_q;
  assign in_comp = in_comp_q;
  assign ready   = ready_q;
  assign err     = err_q;

  // Entry FSM and datapath registers; strobe priority is enter > del > bit_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_STR;
      stringo_q <= '0;
      counter_q <= '0;
      in_comp_q <= '0;
      pat_cnt_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_STR: begin
          if (enter) begin
            // A string shorter than the pattern can never match; refuse it
            if (counter_q >= C_PAT_MIN) begin
              state_q   <= S_PAT;
              pat_cnt_q <= '0;
            end else begin
              err_q <= 1'b1;
            end
          end
`ifdef NHAP_BACKSPACE_EN
          else if (del) begin
            if (counter_q != '0) begin
              // Clearing the removed bit keeps stringo zero above counter
              for (int i = 0; i < MAX_LEN; i++) begin
                if (CNT_W'(i) == (counter_q - C_ONE)) begin
                  stringo_q[i] <= 1'b0;
                end
              end
              counter_q <= counter_q - C_ONE;
            end else begin
              err_q <= 1'b1;
            end
          end
`endif
          else if (bit_valid) begin
            if (counter_q < C_MAX_CNT) begin
              // Inline write decoder: bit lands at the current fill position
              for (int i = 0; i < MAX_LEN; i++) begin
                if (CNT_W'(i) == counter_q) begin
                  stringo_q[i] <= bit_in;
                end
              end
              counter_q <= counter_q + C_ONE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_PAT: begin
          if (enter) begin
            if (pat_cnt_q == C_PAT_FUL) begin
              state_q <= S_RDY;
              ready_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (bit_valid) begin
            if (pat_cnt_q < C_PAT_FUL) begin
              in_comp_q <= {in_comp_q[PAT_LEN-2:0], bit_in};
              pat_cnt_q <= pat_cnt_q + C_PC_ONE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        S_RDY: begin
          // Outputs stay frozen for the scanner until it hands control back
          if (roll_back) begin
            state_q   <= S_STR;
            stringo_q <= '0;
            counter_q <= '0;
            in_comp_q <= '0;
            pat_cnt_q <= '0;
            ready_q   <= 1'b0;
          end
        end

        default: begin
          state_q <= S_STR;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule : nhap_state
`default_nettype wire

// File: tb/tb_nhap_state.sv
`default_nettype none
// ============================================================================
// Module   : tb_nhap_state
// Brief    : Self-checking bench for nhap_state: directed scenarios plus a
//            randomized strobe stream compared against a queue-based model
//            of the entry rules. Honours NHAP_BACKSPACE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nhap_state;

  localparam int ML = 40;
  localparam int PL = 4;
`ifdef NHAP_BACKSPACE_EN
  localparam bit BS = 1'b1;
`else
  localparam bit BS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, bit_valid, bit_in, enter, del, roll_back;
  logic [0:ML-1] stringo;
  logic [7:0]    counter;
  logic [PL-1:0] in_comp;
  logic          ready, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: entered bits kept as plain queues
  bit            str_q[$];
  bit            pat_q[$];
  int            mode;        // 0 string entry, 1 pattern entry, 2 ready
  bit            m_err;
  logic [0:ML-1] m_str;
  logic [7:0]    m_cnt;
  logic [PL-1:0] m_inc;
  bit            m_rdy;

  nhap_state dut (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .enter     (enter),
    .del       (del),
    .roll_back (roll_back),
    .stringo   (stringo),
    .counter   (counter),
    .in_comp   (in_comp),
    .ready     (ready),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs, advance the model, sample 1ns after the edge
  task automatic step(input bit r, input bit bv, input bit bi, input bit en,
                      input bit dl, input bit rb);
    reset = r; bit_valid = bv; bit_in = bi; enter = en; del = dl; roll_back = rb;
    m_err = 1'b0;
    if (r) begin
      str_q.delete(); pat_q.delete(); mode = 0;
    end else if (mode == 0) begin
      if (en) begin
        if (str_q.size() >= PL) begin mode = 1; pat_q.delete(); end
        else m_err = 1'b1;
      end else if (dl && BS) begin
        if (str_q.size() > 0) void'(str_q.pop_back());
        else m_err = 1'b1;
      end else if (bv) begin
        if (str_q.size() < ML) str_q.push_back(bi);
        else m_err = 1'b1;
      end
    end else if (mode == 1) begin
      if (en) begin
        if (pat_q.size() == PL) mode = 2;
        else m_err = 1'b1;
      end else if (bv) begin
        if (pat_q.size() < PL) pat_q.push_back(bi);
        else m_err = 1'b1;
      end
    end else if (rb) begin
      str_q.delete(); pat_q.delete(); mode = 0;
    end
    m_str = '0;
    foreach (str_q[i]) m_str[i] = str_q[i];
    m_cnt = 8'(str_q.size());
    m_inc = '0;
    foreach (pat_q[i]) m_inc = m_inc + (PL'(pat_q[i]) << (pat_q.size() - 1 - i));
    m_rdy = (mode == 2);
    @(posedge clk); #1;
    reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; enter = 1'b0; del = 1'b0; roll_back = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    n_tests++; if (stringo !== '0)  begin n_fail++; $display("FAIL reset_stringo got %h want 0", stringo); end
    n_tests++; if (counter !== 8'd0) begin n_fail++; $display("FAIL reset_counter got %0d want 0", counter); end
    n_tests++; if (in_comp !== 4'd0) begin n_fail++; $display("FAIL reset_in_comp got %b want 0", in_comp); end
    n_tests++; if (ready !== 1'b0)   begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
    n_tests++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_full_entry();
    logic [19:0] s = 20'b1010_1011_0110_1111_0010;
    logic [3:0]  p = 4'b1011;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, s[19-i], 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, p[3-i], 0, 0, 0);
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_early got %b want 0", ready); end
    step(0, 0, 0, 1, 0, 0);
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL full_ready got %b want 1", ready); end
    n_tests++; if (counter !== 8'd20) begin n_fail++; $display("FAIL full_counter got %0d want 20", counter); end
    n_tests++; if (stringo !== {s, 20'b0}) begin n_fail++; $display("FAIL full_stringo got %h want %h", stringo, {s, 20'b0}); end
    n_tests++; if (in_comp !== 4'b1011) begin n_fail++; $display("FAIL full_in_comp got %b want 1011", in_comp); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err got %b want 0", err); end
  endtask

  // Runs directly after test_full_entry, so the DUT is already in ready
  task automatic test_ready_freeze();
    for (int i = 0; i < 6; i++) begin
      step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 0);
      n_tests++; if (stringo !== {20'b1010_1011_0110_1111_0010, 20'b0} || counter !== 8'd20 || in_comp !== 4'b1011)
        begin n_fail++; $display("FAIL freeze_data got %h/%0d/%b want frozen entry", stringo, counter, in_comp); end
      n_tests++; if (err !== 1'b0 || ready !== 1'b1)
        begin n_fail++; $display("FAIL freeze_flags got err=%b ready=%b want err=0 ready=1", err, ready); end
    end
    step(0, 0, 0, 0, 0, 1);
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rollback_ready got %b want 0", ready); end
    n_tests++; if (counter !== 8'd0 || stringo !== '0 || in_comp !== 4'd0)
      begin n_fail++; $display("FAIL rollback_clear got %h/%0d/%b want all 0", stringo, counter, in_comp); end
  endtask

  task automatic test_short_enter();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL short_enter_err got %b want 1", err); end
    n_tests++; if (counter !== 8'd3) begin n_fail++; $display("FAIL short_counter got %0d want 3", counter); end
    step(0, 0, 0, 0, 0, 1);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL short_err_width got %b want 0", err); end
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL short_enter_ok_err got %b want 0", err); end
    step(0, 1, 1, 0, 0, 0);
    n_tests++; if (in_comp !== 4'b0001 || counter !== 8'd5)
      begin n_fail++; $display("FAIL short_in_pat got %b/%0d want 0001/5", in_comp, counter); end
    step(0, 1, 0, 0, 0, 0); step(0, 1, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    n_tests++; if (err !== 1'b1 || in_comp !== 4'b1010)
      begin n_fail++; $display("FAIL pat_overflow got err=%b in_comp=%b want 1/1010", err, in_comp); end
  endtask

  task automatic test_overflow();
    logic [0:41] b;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 42; i++) begin
      b[i] = 1'($urandom_range(0, 1));
      step(0, 1, b[i], 0, 0, 0);
      n_tests++; if (err !== (i >= 40))
        begin n_fail++; $display("FAIL overflow_err bit %0d got %b want %b", i + 1, err, (i >= 40)); end
    end
    n_tests++; if (counter !== 8'd40) begin n_fail++; $display("FAIL overflow_counter got %0d want 40", counter); end
    n_tests++; if (stringo !== b[0:39]) begin n_fail++; $display("FAIL overflow_stringo got %h want %h", stringo, b[0:39]); end
  endtask

  task automatic test_simultaneous();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1'(i & 1), 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    n_tests++; if (counter !== 8'd6 || err !== 1'b0 || stringo !== m_str)
      begin n_fail++; $display("FAIL enter_beats_bit got %0d/%b/%h want 6/0/%h", counter, err, stringo, m_str); end
    step(0, 1, 1, 0, 0, 0);
    n_tests++; if (in_comp !== 4'b0001) begin n_fail++; $display("FAIL enter_bit_in_pat got %b want 0001", in_comp); end
    step(1, 1, 1, 0, 0, 0);
    n_tests++; if (stringo !== '0 || counter !== 8'd0 || in_comp !== 4'd0 || ready !== 1'b0 || err !== 1'b0)
      begin n_fail++; $display("FAIL reset_mid_pat got %h/%0d/%b/%b/%b want all 0", stringo, counter, in_comp, ready, err); end
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    n_tests++; if (counter !== 8'd5 || err !== 1'b0)
      begin n_fail++; $display("FAIL enter_beats_del got %0d/%b want 5/0", counter, err); end
    step(0, 1, 1, 0, 0, 0);
    n_tests++; if (in_comp !== 4'b0001) begin n_fail++; $display("FAIL enter_del_in_pat got %b want 0001", in_comp); end
  endtask

  task automatic test_backspace();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0); step(0, 1, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
`ifdef NHAP_BACKSPACE_EN
    n_tests++; if (counter !== 8'd2 || stringo[2] !== 1'b0 || stringo[0:1] !== 2'b11 || err !== 1'b0)
      begin n_fail++; $display("FAIL bksp_del got %0d/%h/%b want 2/c000000000/0", counter, stringo, err); end
    step(0, 1, 1, 0, 1, 0);
    n_tests++; if (counter !== 8'd1) begin n_fail++; $display("FAIL bksp_del_beats_bit got %0d want 1", counter); end
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    n_tests++; if (err !== 1'b1 || counter !== 8'd0)
      begin n_fail++; $display("FAIL bksp_empty got err=%b cnt=%0d want 1/0", err, counter); end
`else
    n_tests++; if (counter !== 8'd3 || stringo[0:2] !== 3'b110 || err !== 1'b0)
      begin n_fail++; $display("FAIL nobksp_del got %0d/%h/%b want 3/c000000000/0", counter, stringo, err); end
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    n_tests++; if (err !== 1'b0 || counter !== 8'd0)
      begin n_fail++; $display("FAIL nobksp_empty got err=%b cnt=%0d want 0/0", err, counter); end
`endif
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 15));
      n_tests++; if (stringo !== m_str) begin n_fail++; $display("FAIL rand_stringo cyc %0d got %h want %h", n, stringo, m_str); end
      n_tests++; if (counter !== m_cnt) begin n_fail++; $display("FAIL rand_counter cyc %0d got %0d want %0d", n, counter, m_cnt); end
      n_tests++; if (in_comp !== m_inc) begin n_fail++; $display("FAIL rand_in_comp cyc %0d got %b want %b", n, in_comp, m_inc); end
      n_tests++; if (ready !== m_rdy)   begin n_fail++; $display("FAIL rand_ready cyc %0d got %b want %b", n, ready, m_rdy); end
      n_tests++; if (err !== m_err)     begin n_fail++; $display("FAIL rand_err cyc %0d got %b want %b", n, err, m_err); end
    end
  endtask

  initial begin
    reset = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; enter = 1'b0; del = 1'b0; roll_back = 1'b0;
    mode = 0;
    test_reset();
    test_full_entry();
    test_ready_freeze();
    test_short_enter();
    test_overflow();
    test_simultaneous();
    test_backspace();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_nhap_state
`default_nettype wire
